// File: rtl/cntr_bcd_display.sv
// Binary-to-BCD converter using a sequential double-dabble, driving a 3-digit multiplexed 7-segment display.
// Optional leading-zero blanking on the display is enabled with CNTR_BCD_LZ_BLANK_EN; bcd is unaffected by it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for q_in to differ from the last converted value (or for the post-reset conversion)
// S_SHIFT | double-dabble: adjust the nibbles, then shift; 8 iterations
// S_DONE  | publish acc to bcd, pulse bcd_valid, remember the converted value
module cntr_bcd_display #(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  q_in,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [1:0]    state;
    logic [7:0]    sreg;
    logic [7:0]    q_cap;
    logic [7:0]    q_last;
    logic [11:0]   acc;
    logic [11:0]   acc_adj;
    logic [2:0]    iter;
    logic          init_pend;
    logic [PW-1:0] presc;
    logic [1:0]    dig_idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_raw;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // iter is a down-counter: loaded with 7, so eight shifts happen before S_DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sreg      <= 8'd0;
            q_cap     <= 8'd0;
            q_last    <= 8'd0;
            acc       <= 12'd0;
            iter      <= 3'd0;
            init_pend <= 1'b1;
            bcd       <= 12'h000;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((q_in != q_last) || init_pend) begin
                        sreg  <= q_in;
                        q_cap <= q_in;
                        acc   <= 12'd0;
                        iter  <= 3'd7;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc  <= {acc_adj[10:0], sreg[7]};
                    sreg <= {sreg[6:0], 1'b0};
                    if (iter == 3'd0)
                        state <= S_DONE;
                    else
                        iter <= iter - 3'd1;
                end
                S_DONE: begin
                    bcd       <= acc;
                    q_last    <= q_cap;
                    init_pend <= 1'b0;
                    bcd_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            dig_idx <= 2'd0;
        end else if (presc == PRESC_MAX) begin
            presc   <= '0;
            dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        an    = 3'b111;
        nib   = 4'd0;
        blank = 1'b0;
        case (dig_idx)
            2'd0: begin
                an  = 3'b110;
                nib = bcd[3:0];
            end
            2'd1: begin
                an  = 3'b101;
                nib = bcd[7:4];
`ifdef CNTR_BCD_LZ_BLANK_EN
                blank = (bcd[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                an  = 3'b011;
                nib = bcd[11:8];
`ifdef CNTR_BCD_LZ_BLANK_EN
                blank = (bcd[11:8] == 4'd0);
`endif
            end
            default: begin
                an  = 3'b111;
                nib = 4'd0;
            end
        endcase
        seg_raw = blank ? 7'h00 : seg_decode(nib);
        seg     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    end

endmodule
